// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// mem_arbiter_if : datapath request/response and RAM strobe bundle
// Revision 1.0
// ============================================================================
interface mem_arbiter_if #(
   parameter int ADDR_W = 32
);
   logic              imemREN;
   logic [ADDR_W-1:0] imemaddr;
   logic [31:0]       imemload;
   logic              ihit;
   logic              dmemREN;
   logic              dmemWEN;
   logic [ADDR_W-1:0] dmemaddr;
   logic [31:0]       dmemstore;
   logic [31:0]       dmemload;
   logic              dhit;
   logic              halt;
   logic              halted;
   logic              ramREN;
   logic              ramWEN;
   logic [ADDR_W-1:0] ramaddr;
   logic [31:0]       ramstore;
   logic [31:0]       ramload;
   logic              ram_ready;

   // Arbiter view: takes requests and RAM responses, drives hits and strobes.
   modport slave (
      input  imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore, halt,
             ramload, ram_ready,
      output imemload, ihit, dmemload, dhit, halted,
             ramREN, ramWEN, ramaddr, ramstore
   );

   modport master (
      output imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore, halt,
             ramload, ram_ready,
      input  imemload, ihit, dmemload, dhit, halted,
             ramREN, ramWEN, ramaddr, ramstore
   );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// mem_arbiter : single-port RAM arbiter, data priority with fetch anti-starvation
// Revision 1.0
// ============================================================================
module mem_arbiter #(
   parameter int MAX_DSTREAK = 4,
   parameter int ADDR_W      = 32
) (
   input logic          CLK,
   input logic          RST,
   mem_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_IACC   = 2'd1,
      S_DACC   = 2'd2,
      S_HALTED = 2'd3
   } state_t;

   localparam logic [3:0] c_max_dstreak = 4'(MAX_DSTREAK);

   state_t            r_state;
   state_t            w_state_nxt;
   logic              w_dreq;
   logic              w_grant_i;
   logic              w_grant_d;
   logic              w_done;
   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_store;
   logic              r_wr;
   logic [3:0]        r_dstreak;
   logic [31:0]       r_imemload;
   logic [31:0]       r_dmemload;
   logic              r_ihit;
   logic              r_dhit;

   assign w_dreq = bus.dmemREN | bus.dmemWEN;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_grant_i   = 1'b0;
      w_grant_d   = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.halt) begin
               w_state_nxt = S_HALTED;
            end else if (w_dreq && bus.imemREN) begin
               // Data wins unless it has already starved the fetch for the full streak
               if (r_dstreak == c_max_dstreak) begin
                  w_grant_i   = 1'b1;
                  w_state_nxt = S_IACC;
               end else begin
                  w_grant_d   = 1'b1;
                  w_state_nxt = S_DACC;
               end
            end else if (bus.imemREN) begin
               w_grant_i   = 1'b1;
               w_state_nxt = S_IACC;
            end else if (w_dreq) begin
               w_grant_d   = 1'b1;
               w_state_nxt = S_DACC;
            end
         end
         S_IACC, S_DACC: begin
            if (bus.ram_ready) begin
               w_done      = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         S_HALTED: begin
            w_state_nxt = S_HALTED;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_addr     <= '0;
         r_store    <= '0;
         r_wr       <= 1'b0;
         r_dstreak  <= 4'd0;
         r_imemload <= '0;
         r_dmemload <= '0;
         r_ihit     <= 1'b0;
         r_dhit     <= 1'b0;
      end else begin
         r_ihit <= w_done && (r_state == S_IACC);
         r_dhit <= w_done && (r_state == S_DACC);
         if (w_grant_i) begin
            r_addr    <= bus.imemaddr;
            r_wr      <= 1'b0;
            r_dstreak <= 4'd0;
         end
         if (w_grant_d) begin
            r_addr  <= bus.dmemaddr;
            r_store <= bus.dmemstore;
            r_wr    <= bus.dmemWEN;
         end
         if (w_done && (r_state == S_IACC)) begin
            r_imemload <= bus.ramload;
         end
         // Streak only grows while a fetch is actually being held off
         if (w_done && (r_state == S_DACC)) begin
            if (!r_wr) begin
               r_dmemload <= bus.ramload;
            end
            if (bus.imemREN) begin
               if (r_dstreak != c_max_dstreak) begin
                  r_dstreak <= r_dstreak + 4'd1;
               end
            end else begin
               r_dstreak <= 4'd0;
            end
         end
      end
   end

   assign bus.ramREN   = (r_state == S_IACC) || ((r_state == S_DACC) && !r_wr);
   assign bus.ramWEN   = (r_state == S_DACC) && r_wr;
   assign bus.ramaddr  = ((r_state == S_IACC) || (r_state == S_DACC)) ? r_addr : '0;
   assign bus.ramstore = (r_state == S_DACC) ? r_store : '0;
   assign bus.imemload = r_imemload;
   assign bus.dmemload = r_dmemload;
   assign bus.ihit     = r_ihit;
   assign bus.dhit     = r_dhit;
   assign bus.halted   = (r_state == S_HALTED);

endmodule
`default_nettype wire
